// File: rtl/key_press_reader.sv
// key_press_reader: synchronizes and debounces one active-low pushbutton.
// It produces one-cycle press and release strobes and a debounced level,
// and it counts accepted presses.
//
// Ports:
//   CLOCK_50  in   system clock; all logic runs on the rising edge
//   Resetn    in   asynchronous active-low reset
//   KEY       in   raw pushbutton, active-low, asynchronous to CLOCK_50
//   Press     out  one-cycle strobe when a press is accepted
//   Release   out  one-cycle strobe when a release is accepted
//   Pressed   out  debounced level (1 = button held)
//   Count     out  accepted presses, modulo 2**COUNT_W
//   LEDR      out  Count fitted to 10 bits (zero-extended or truncated)
module key_press_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TW              = 20,
  parameter int unsigned COUNT_W         = 10
) (
  input  logic               CLOCK_50,
  input  logic               Resetn,
  input  logic               KEY,
  output logic               Press,
  output logic               Release,
  output logic               Pressed,
  output logic [COUNT_W-1:0] Count,
  output logic [9:0]         LEDR
);

  localparam int unsigned LEDR_W = 10;
  // Timer value on the last stable edge of a check window
  localparam logic [TW-1:0] TIMER_LAST = TW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               k1_q, ks_q;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               pressed_q, pressed_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Two-flop synchronizer; both flops reset to the released level
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      k1_q <= 1'b1;
      ks_q <= 1'b1;
    end else begin
      k1_q <= KEY;
      ks_q <= k1_q;
    end
  end

  // State, timer and registered outputs
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= ST_RELEASED;
      timer_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      pressed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      press_q   <= press_d;
      release_q <= release_d;
      pressed_q <= pressed_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic: a check state moves forward only after the full window
  // of stable ks, and falls back on any bounce without a strobe
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;

    unique case (state_q)
      ST_RELEASED: begin
        if (!ks_q) begin
          state_d = ST_PRESS_CHK;
          timer_d = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (ks_q) begin
          state_d = ST_RELEASED;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_HELD;
          press_d = 1'b1;
          count_d = count_q + COUNT_W'(1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_HELD: begin
        if (ks_q) begin
          state_d = ST_RELEASE_CHK;
          timer_d = '0;
        end
      end
      ST_RELEASE_CHK: begin
        if (!ks_q) begin
          state_d = ST_HELD;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = ST_RELEASED;
          release_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_RELEASED;
    endcase

    // Debounced level follows the state being entered on this edge
    pressed_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_CHK);
  end

  assign Press   = press_q;
  assign Release = release_q;
  assign Pressed = pressed_q;
  assign Count   = count_q;
  // Sized cast zero-extends a narrow count or keeps the low 10 bits of a wide one
  assign LEDR    = LEDR_W'(count_q);

endmodule

// File: tb/tb_key_press_reader.sv
// Directed bench for key_press_reader with a 4-cycle debounce window.
// dut_a uses a 10-bit count; dut_b shares its inputs and uses a 3-bit
// count for the wrap check.
module tb_key_press_reader;

  logic       clk = 1'b0;
  logic       rstn;
  logic       key;
  logic       a_press, a_release, a_pressed;
  logic [9:0] a_count, a_ledr;
  logic       b_press, b_release, b_pressed;
  logic [2:0] b_count;
  logic [9:0] b_ledr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_press_reader #(.DEBOUNCE_CYCLES(4), .TW(3), .COUNT_W(10)) dut_a (
    .CLOCK_50(clk), .Resetn(rstn), .KEY(key),
    .Press(a_press), .Release(a_release), .Pressed(a_pressed),
    .Count(a_count), .LEDR(a_ledr)
  );

  key_press_reader #(.DEBOUNCE_CYCLES(4), .TW(3), .COUNT_W(3)) dut_b (
    .CLOCK_50(clk), .Resetn(rstn), .KEY(key),
    .Press(b_press), .Release(b_release), .Pressed(b_pressed),
    .Count(b_count), .LEDR(b_ledr)
  );

  typedef struct {
    logic       rstn;
    logic       key;
    logic       press;
    logic       rel;
    logic       held;
    logic [9:0] count;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic k, input logic p,
                              input logic rl, input logic h, input int c);
    vec_t v;
    v.rstn = r; v.key = k; v.press = p; v.rel = rl; v.held = h; v.count = 10'(c);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int step, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input int step, input logic p,
                       input logic rl, input logic h, input int c);
    chk({name, ".press"},   step, int'(a_press),   int'(p));
    chk({name, ".release"}, step, int'(a_release), int'(rl));
    chk({name, ".pressed"}, step, int'(a_pressed), int'(h));
    chk({name, ".count"},   step, int'(a_count),   c);
    chk({name, ".ledr"},    step, int'(a_ledr),    c);
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later
  task automatic step(input logic r, input logic k);
    rstn = r;
    key  = k;
    @(posedge clk);
    #1;
  endtask

  // Strobes may never coincide on either instance
  always @(negedge clk) begin
    if (rstn) begin
      chk("no_dual_strobe_a", 0, int'(a_press & a_release), 0);
      chk("no_dual_strobe_b", 0, int'(b_press & b_release), 0);
    end
  end

  initial begin
    // Bounce sequence low3/high1/low2/high1/low10: accepted on edge 13 only
    add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,1,0,0,0,0);
    add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,1,0,0,0,0);
    add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,0,0,0,0,0);
    add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,0,1,0,1,1);
    add(1,0,0,0,1,1); add(1,0,0,0,1,1); add(1,0,0,0,1,1);
    // Key released: accepted 6 edges later
    add(1,1,0,0,1,1); add(1,1,0,0,1,1); add(1,1,0,0,1,1); add(1,1,0,0,1,1);
    add(1,1,0,0,1,1); add(1,1,0,0,1,1); add(1,1,0,1,0,1); add(1,1,0,0,0,1);
    // Reset across an edge, then a 3-cycle press that must be rejected
    add(0,1,0,0,0,0);
    add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,0,0,0,0,0);
    add(1,1,0,0,0,0); add(1,1,0,0,0,0); add(1,1,0,0,0,0);
    add(1,1,0,0,0,0); add(1,1,0,0,0,0);

    // Reset state before any clock edge
    rstn = 1'b0;
    key  = 1'b1;
    #2;
    chk_a("reset_initial", 0, 0, 0, 0, 0);
    chk("reset_initial.b_count", 0, int'(b_count), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 1);

    // Clean press held 20 cycles, then released 20 cycles
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      chk_a("clean_press", i, i == 6, 0, i >= 6, (i >= 6) ? 1 : 0);
    end
    for (int i = 0; i < 20; i++) begin
      step(1, 1);
      chk_a("clean_release", i, 0, i == 6, i < 6, 1);
    end

    // Asynchronous reset between edges clears everything before the next edge
    rstn = 1'b0;
    #2;
    chk_a("async_reset", 0, 0, 0, 0, 0);
    rstn = 1'b1;
    #1;

    // Vector table
    foreach (vecs[i]) begin
      step(vecs[i].rstn, vecs[i].key);
      chk_a("vec", i, vecs[i].press, vecs[i].rel, vecs[i].held, int'(vecs[i].count));
    end

    // Reset pulse during PRESS_CHK with key still held low
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      chk_a("pre_abort", i, 0, 0, 0, 0);
    end
    step(0, 0);
    chk_a("abort_reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, 0);
      chk_a("post_abort", i, i == 6, 0, i == 6, (i == 6) ? 1 : 0);
    end
    for (int i = 0; i < 10; i++) step(1, 1);
    chk_a("post_abort_idle", 0, 0, 0, 0, 1);

    // Eight clean presses: the 3-bit count wraps to 0, the 10-bit one reaches 8
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    #1;
    for (int p = 1; p <= 8; p++) begin
      for (int i = 0; i < 8; i++) step(1, 0);
      chk("wrap.b_count", p, int'(b_count), p % 8);
      chk("wrap.b_ledr",  p, int'(b_ledr),  p % 8);
      chk("wrap.a_count", p, int'(a_count), p);
      chk("wrap.b_pressed", p, int'(b_pressed), 1);
      for (int i = 0; i < 8; i++) step(1, 1);
      chk("wrap.b_released", p, int'(b_pressed), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
